// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 double-buffered frame store.
package hub75_pkg;

   localparam int ROW_BITS      = 192;
   localparam int NUM_SCAN      = 4;
   localparam int WORD_W        = 16;
   localparam int WORDS_PER_ROW = ROW_BITS / WORD_W;
   localparam int ROW_ADDR_W    = $clog2(NUM_SCAN);
   localparam int WORD_ADDR_W   = $clog2(WORDS_PER_ROW);

   typedef logic [ROW_BITS-1:0] row_t;

   typedef enum logic {
      ACTIVE    = 1'b0,
      SWAP_PEND = 1'b1
   } fb_state_e;

   // 0xAA.. checkerboard: odd columns lit, even columns dark.
   function automatic row_t test_pattern();
      return {(ROW_BITS/2){2'b10}};
   endfunction

endpackage

// File: rtl/hub75_frame_buffer_if.sv
// Host write, swap and scan-driver read channels of the frame buffer.
interface hub75_frame_buffer_if;
   import hub75_pkg::*;

   logic                   wr_valid;
   logic                   wr_ready;
   logic                   wr_half;
   logic [ROW_ADDR_W-1:0]  wr_row;
   logic [WORD_ADDR_W-1:0] wr_word;
   logic [WORD_W-1:0]      wr_data;
   logic                   swap_req;
   logic                   swap_done;
   logic                   rd_req;
   logic [ROW_ADDR_W-1:0]  rd_row;
   logic                   rd_valid;
   row_t                   rd_top;
   row_t                   rd_bot;

   modport master (
      output wr_valid, wr_half, wr_row, wr_word, wr_data, swap_req, rd_req, rd_row,
      input  wr_ready, swap_done, rd_valid, rd_top, rd_bot
   );

   modport slave (
      input  wr_valid, wr_half, wr_row, wr_word, wr_data, swap_req, rd_req, rd_row,
      output wr_ready, swap_done, rd_valid, rd_top, rd_bot
   );

endinterface

// File: rtl/hub75_row_bank.sv
// One frame bank: two halves of NUM_SCAN rows, word-wide write, full row-pair read.
module hub75_row_bank
   import hub75_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we_i,
   input  logic                   wr_half_i,
   input  logic [ROW_ADDR_W-1:0]  wr_row_i,
   input  logic [WORD_ADDR_W-1:0] wr_word_i,
   input  logic [WORD_W-1:0]      wr_data_i,
   input  logic [ROW_ADDR_W-1:0]  rd_row_i,
   output row_t                   rd_top_o,
   output row_t                   rd_bot_o
);

   row_t mem_q [2][NUM_SCAN];

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the panel must come up dark, so every row is cleared; this keeps the store in flops, not RAM.
         for (int h = 0; h < 2; h++) begin
            for (int r = 0; r < NUM_SCAN; r++) begin
               mem_q[h][r] <= '0;
            end
         end
      end else if (we_i) begin
         mem_q[wr_half_i][wr_row_i][int'(wr_word_i) * WORD_W +: WORD_W] <= wr_data_i;
      end
   end

   assign rd_top_o = mem_q[0][rd_row_i];
   assign rd_bot_o = mem_q[1][rd_row_i];

endmodule

// File: rtl/hub75_frame_buffer.sv
// Double-buffered HUB75 frame store with swap deferred to the row-0 frame boundary.
// Optional HUB75_TEST_PATTERN_EN adds pattern_en, forcing a checkerboard on reads.
module hub75_frame_buffer
   import hub75_pkg::*;
(
   input  logic clk,
   input  logic rst,
`ifdef HUB75_TEST_PATTERN_EN
   input  logic pattern_en,
`endif
   hub75_frame_buffer_if.slave fb
);

   fb_state_e state_q, state_d;
   logic      front_q, front_d;
   logic      boundary;
   logic      wr_ready_q, rd_valid_q, swap_done_q;
   row_t      rd_top_q, rd_bot_q;
   row_t      b0_top, b0_bot, b1_top, b1_bot;
   row_t      sel_top, sel_bot;
   logic      wr_fire;

   assign wr_fire = fb.wr_valid & wr_ready_q &
                    (fb.wr_word < WORD_ADDR_W'(WORDS_PER_ROW));

   // Writes go only to the back bank, i.e. the one not selected by front_q.
   hub75_row_bank u_bank0 (
      .clk       (clk),
      .rst       (rst),
      .we_i      (wr_fire & front_q),
      .wr_half_i (fb.wr_half),
      .wr_row_i  (fb.wr_row),
      .wr_word_i (fb.wr_word),
      .wr_data_i (fb.wr_data),
      .rd_row_i  (fb.rd_row),
      .rd_top_o  (b0_top),
      .rd_bot_o  (b0_bot)
   );

   hub75_row_bank u_bank1 (
      .clk       (clk),
      .rst       (rst),
      .we_i      (wr_fire & ~front_q),
      .wr_half_i (fb.wr_half),
      .wr_row_i  (fb.wr_row),
      .wr_word_i (fb.wr_word),
      .wr_data_i (fb.wr_data),
      .rd_row_i  (fb.rd_row),
      .rd_top_o  (b1_top),
      .rd_bot_o  (b1_bot)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d  = state_q;
      front_d  = front_q;
      boundary = 1'b0;
      unique case (state_q)
         ACTIVE: begin
            if (fb.swap_req) state_d = SWAP_PEND;
         end
         SWAP_PEND: begin
            if (fb.rd_req && fb.rd_row == '0) begin
               boundary = 1'b1;
               front_d  = ~front_q;
               state_d  = ACTIVE;
            end
         end
         default: state_d = ACTIVE;
      endcase
   end

   // Selecting on front_d lets the boundary read already return the new frame.
   always_comb begin
      sel_top = front_d ? b1_top : b0_top;
      sel_bot = front_d ? b1_bot : b0_bot;
`ifdef HUB75_TEST_PATTERN_EN
      if (pattern_en) begin
         sel_top = test_pattern();
         sel_bot = test_pattern();
      end
`endif
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      if (rst) begin
         state_q     <= ACTIVE;
         front_q     <= 1'b0;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         swap_done_q <= 1'b0;
         rd_top_q    <= '0;
         rd_bot_q    <= '0;
      end else begin
         state_q     <= state_d;
         front_q     <= front_d;
         wr_ready_q  <= (state_d == ACTIVE);
         rd_valid_q  <= fb.rd_req;
         swap_done_q <= boundary;
         if (fb.rd_req) begin
            rd_top_q <= sel_top;
            rd_bot_q <= sel_bot;
         end
      end
   end

   assign fb.wr_ready  = wr_ready_q;
   assign fb.rd_valid  = rd_valid_q;
   assign fb.swap_done = swap_done_q;
   assign fb.rd_top    = rd_top_q;
   assign fb.rd_bot    = rd_bot_q;

endmodule

// File: tb/tb_hub75_frame_buffer.sv
// Directed self-checking bench for hub75_frame_buffer: reset, writes, deferred swap, reset mid-swap.
module tb_hub75_frame_buffer;
   import hub75_pkg::*;

   logic clk;
   logic rst;
   logic pattern_en;
   int   n_chk;
   int   n_err;
   int   swap_cnt;
   row_t exp_top;
   row_t exp_bot;

   hub75_frame_buffer_if fb ();

   hub75_frame_buffer dut (
      .clk        (clk),
      .rst        (rst),
`ifdef HUB75_TEST_PATTERN_EN
      .pattern_en (pattern_en),
`endif
      .fb         (fb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input row_t got, input row_t exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (fb.swap_done === 1'b1) swap_cnt++;
   endtask

   task automatic write_word(input logic half, input logic [ROW_ADDR_W-1:0] row,
                             input logic [WORD_ADDR_W-1:0] word, input logic [WORD_W-1:0] data);
      fb.wr_valid = 1'b1;
      fb.wr_half  = half;
      fb.wr_row   = row;
      fb.wr_word  = word;
      fb.wr_data  = data;
      tick();
      fb.wr_valid = 1'b0;
   endtask

   task automatic read_row(input logic [ROW_ADDR_W-1:0] row);
      fb.rd_req = 1'b1;
      fb.rd_row = row;
      tick();
      fb.rd_req = 1'b0;
   endtask

   task automatic pulse_swap();
      fb.swap_req = 1'b1;
      tick();
      fb.swap_req = 1'b0;
   endtask

   initial begin
      n_chk       = 0;
      n_err       = 0;
      swap_cnt    = 0;
      rst         = 1'b1;
      pattern_en  = 1'b0;
      fb.wr_valid = 1'b0;
      fb.wr_half  = 1'b0;
      fb.wr_row   = '0;
      fb.wr_word  = '0;
      fb.wr_data  = '0;
      fb.swap_req = 1'b0;
      fb.rd_req   = 1'b0;
      fb.rd_row   = '0;

      // 1: reset state, first read after reset
      tick();
      tick();
      check("rst_wr_ready", row_t'(fb.wr_ready), '0);
      check("rst_rd_valid", row_t'(fb.rd_valid), '0);
      check("rst_swap_done", row_t'(fb.swap_done), '0);
      check("rst_rd_top", fb.rd_top, '0);
      rst = 1'b0;
      read_row(2);
      check("t1_wr_ready", row_t'(fb.wr_ready), row_t'(1));
      check("t1_rd_valid", row_t'(fb.rd_valid), row_t'(1));
      check("t1_rd_top", fb.rd_top, '0);
      check("t1_rd_bot", fb.rd_bot, '0);
      tick();
      check("t1_rd_valid_pulse", row_t'(fb.rd_valid), '0);

      // 2: fill back bank, swap at row 0, read back
      write_word(1'b0, 1, 0, 16'h00FF);
      write_word(1'b0, 1, 11, 16'h8000);
      write_word(1'b1, 1, 3, 16'h1234);
      write_word(1'b0, 1, 12, 16'hFFFF);
      read_row(1);
      check("t2_front_untouched", fb.rd_top, '0);
      pulse_swap();
      check("t2_pend_wr_ready", row_t'(fb.wr_ready), '0);
      read_row(1);
      check("t2_no_swap_row1", row_t'(fb.swap_done), '0);
      check("t2_old_front", fb.rd_top, '0);
      read_row(0);
      check("t2_swap_done", row_t'(fb.swap_done), row_t'(1));
      check("t2_rd_valid", row_t'(fb.rd_valid), row_t'(1));
      tick();
      check("t2_swap_done_pulse", row_t'(fb.swap_done), '0);
      check("t2_wr_ready_back", row_t'(fb.wr_ready), row_t'(1));
      read_row(1);
      exp_top        = '0;
      exp_top[15:0]  = 16'h00FF;
      exp_top[191]   = 1'b1;
      exp_bot        = '0;
      exp_bot[63:48] = 16'h1234;
      check("t2_rd_top", fb.rd_top, exp_top);
      check("t2_rd_bot", fb.rd_bot, exp_bot);

      // 3: pending swap freezes writes until a row-0 read
      pulse_swap();
      read_row(3);
      check("t3_no_swap_row3", row_t'(fb.swap_done), '0);
      check("t3_wr_ready_low", row_t'(fb.wr_ready), '0);
      fb.wr_valid = 1'b1;
      fb.wr_half  = 1'b0;
      fb.wr_row   = 2;
      fb.wr_word  = 0;
      fb.wr_data  = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_held_wr_ready", row_t'(fb.wr_ready), '0);
      end
      read_row(0);
      check("t3_swap_done", row_t'(fb.swap_done), row_t'(1));
      check("t3_new_front_row0", fb.rd_top, '0);
      tick();
      fb.wr_valid = 1'b0;
      read_row(2);
      check("t3_frozen_bank", fb.rd_top, '0);

      // 4: repeated swap_req in SWAP_PEND yields a single swap
      swap_cnt = 0;
      pulse_swap();
      tick();
      pulse_swap();
      read_row(0);
      read_row(2);
      exp_top       = '0;
      exp_top[15:0] = 16'hBEEF;
      check("t4_post_freeze_write", fb.rd_top, exp_top);
      read_row(1);
      exp_top       = '0;
      exp_top[15:0] = 16'h00FF;
      exp_top[191]  = 1'b1;
      check("t4_front_once", fb.rd_top, exp_top);
      tick();
      tick();
      check("t4_swap_count", row_t'(swap_cnt), row_t'(1));

      // 4b: swap_req, write and row-0 read in the same ACTIVE cycle
      fb.wr_valid = 1'b1;
      fb.wr_half  = 1'b0;
      fb.wr_row   = 0;
      fb.wr_word  = 5;
      fb.wr_data  = 16'hC3C3;
      fb.swap_req = 1'b1;
      fb.rd_req   = 1'b1;
      fb.rd_row   = 0;
      tick();
      fb.wr_valid = 1'b0;
      fb.swap_req = 1'b0;
      fb.rd_req   = 1'b0;
      check("t4b_no_swap", row_t'(fb.swap_done), '0);
      check("t4b_old_front_row0", fb.rd_top, '0);
      check("t4b_pending", row_t'(fb.wr_ready), '0);
      read_row(0);
      exp_top        = '0;
      exp_top[95:80] = 16'hC3C3;
      check("t4b_swap_done", row_t'(fb.swap_done), row_t'(1));
      check("t4b_new_front_row0", fb.rd_top, exp_top);

      // 5: reset during SWAP_PEND discards the swap and clears both banks
      swap_cnt = 0;
      pulse_swap();
      check("t5_pending", row_t'(fb.wr_ready), '0);
      rst = 1'b1;
      tick();
      tick();
      check("t5_rst_wr_ready", row_t'(fb.wr_ready), '0);
      check("t5_rst_rd_valid", row_t'(fb.rd_valid), '0);
      check("t5_rst_rd_top", fb.rd_top, '0);
      rst = 1'b0;
      tick();
      check("t5_wr_ready_up", row_t'(fb.wr_ready), row_t'(1));
      read_row(0);
      check("t5_no_swap", row_t'(swap_cnt), '0);
      check("t5_bank0_row0", fb.rd_top, '0);
      read_row(1);
      check("t5_bank0_row1", fb.rd_top, '0);
      pulse_swap();
      read_row(0);
      read_row(1);
      check("t5_bank1_cleared", fb.rd_top, '0);
      check("t5_swap_count", row_t'(swap_cnt), row_t'(1));

`ifdef HUB75_TEST_PATTERN_EN
      // 6: test pattern overrides bank contents
      pattern_en = 1'b1;
      read_row(0);
      exp_top = test_pattern();
      check("t6_pattern_top", fb.rd_top, exp_top);
      check("t6_pattern_bot", fb.rd_bot, exp_top);
      check("t6_pattern_valid", row_t'(fb.rd_valid), row_t'(1));
      pattern_en = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
